// File: rtl/dispatcher_if.sv
// Issue-stage bus between the instruction queue, RF, ROB, both CDBs and the RS/LSB.
// The slave modport is the dispatcher's view and the master modport is the surrounding pipeline's view.
interface dispatcher_if #(
   parameter int DATA_W   = 32,
   parameter int ROB_ID_W = 5,
   parameter int OPENUM_W = 6
);
   logic                rdy;
   logic                misbranch_flag;

   logic                inst_valid;
   logic [OPENUM_W-1:0] inst_openum;
   logic [4:0]          inst_rd;
   logic [4:0]          inst_rs1;
   logic [4:0]          inst_rs2;
   logic                inst_use_rs2;
   logic                inst_is_ls;
   logic [DATA_W-1:0]   inst_pc;
   logic [DATA_W-1:0]   inst_imm;
   logic                dispatch_ready;

   logic [4:0]          rf_rs1_idx;
   logic [4:0]          rf_rs2_idx;
   logic [DATA_W-1:0]   rf_V1;
   logic [DATA_W-1:0]   rf_V2;
   logic [ROB_ID_W-1:0] rf_Q1;
   logic [ROB_ID_W-1:0] rf_Q2;
   logic                rename_en;
   logic [4:0]          rename_rd;
   logic [ROB_ID_W-1:0] rename_rob_id;

   logic                rob_full;
   logic [ROB_ID_W-1:0] rob_free_id;
   logic                rob_alloc_en;
   logic [4:0]          rob_alloc_rd;
   logic [OPENUM_W-1:0] rob_alloc_openum;
   logic [DATA_W-1:0]   rob_alloc_pc;
   logic [ROB_ID_W-1:0] rob_q1_query;
   logic [ROB_ID_W-1:0] rob_q2_query;
   logic                rob_q1_ready;
   logic                rob_q2_ready;
   logic [DATA_W-1:0]   rob_q1_value;
   logic [DATA_W-1:0]   rob_q2_value;

   logic                arith_cdb_valid;
   logic [ROB_ID_W-1:0] arith_cdb_rob_id;
   logic [DATA_W-1:0]   arith_cdb_result;
   logic                ls_cdb_valid;
   logic [ROB_ID_W-1:0] ls_cdb_rob_id;
   logic [DATA_W-1:0]   ls_cdb_result;

   logic                rs_full;
   logic                lsb_full;
   logic                rs_en;
   logic                lsb_en;
   logic [OPENUM_W-1:0] out_openum;
   logic [DATA_W-1:0]   out_V1;
   logic [DATA_W-1:0]   out_V2;
   logic [ROB_ID_W-1:0] out_Q1;
   logic [ROB_ID_W-1:0] out_Q2;
   logic [DATA_W-1:0]   out_pc;
   logic [DATA_W-1:0]   out_imm;
   logic [ROB_ID_W-1:0] out_rob_id;

   modport slave (
      input  rdy, misbranch_flag,
      input  inst_valid, inst_openum, inst_rd, inst_rs1, inst_rs2, inst_use_rs2,
      input  inst_is_ls, inst_pc, inst_imm,
      output dispatch_ready,
      output rf_rs1_idx, rf_rs2_idx,
      input  rf_V1, rf_V2, rf_Q1, rf_Q2,
      output rename_en, rename_rd, rename_rob_id,
      input  rob_full, rob_free_id,
      output rob_alloc_en, rob_alloc_rd, rob_alloc_openum, rob_alloc_pc,
      output rob_q1_query, rob_q2_query,
      input  rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
      input  arith_cdb_valid, arith_cdb_rob_id, arith_cdb_result,
      input  ls_cdb_valid, ls_cdb_rob_id, ls_cdb_result,
      input  rs_full, lsb_full,
      output rs_en, lsb_en, out_openum, out_V1, out_V2, out_Q1, out_Q2,
      output out_pc, out_imm, out_rob_id
   );

   modport master (
      output rdy, misbranch_flag,
      output inst_valid, inst_openum, inst_rd, inst_rs1, inst_rs2, inst_use_rs2,
      output inst_is_ls, inst_pc, inst_imm,
      input  dispatch_ready,
      input  rf_rs1_idx, rf_rs2_idx,
      output rf_V1, rf_V2, rf_Q1, rf_Q2,
      input  rename_en, rename_rd, rename_rob_id,
      output rob_full, rob_free_id,
      input  rob_alloc_en, rob_alloc_rd, rob_alloc_openum, rob_alloc_pc,
      input  rob_q1_query, rob_q2_query,
      output rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
      output arith_cdb_valid, arith_cdb_rob_id, arith_cdb_result,
      output ls_cdb_valid, ls_cdb_rob_id, ls_cdb_result,
      output rs_full, lsb_full,
      input  rs_en, lsb_en, out_openum, out_V1, out_V2, out_Q1, out_Q2,
      input  out_pc, out_imm, out_rob_id
   );
endinterface

// File: rtl/dispatcher.sv
// Issue stage: allocates ROB and rename entries on the IQ handshake, resolves V/Q operands,
// and delivers a registered, CDB-clean payload to the RS or LSB one cycle later.
module dispatcher #(
   parameter int DATA_W   = 32,
   parameter int ROB_ID_W = 5,
   parameter int OPENUM_W = 6
) (
   input logic        clk,
   input logic        rst,
   dispatcher_if.slave bus
);
   localparam logic [ROB_ID_W-1:0] ZERO_ROB = '0;
   localparam logic [OPENUM_W-1:0] NOP      = '0;

   logic                r_rs_en;
   logic                r_lsb_en;
   logic [OPENUM_W-1:0] r_openum;
   logic [DATA_W-1:0]   r_V1;
   logic [DATA_W-1:0]   r_V2;
   logic [ROB_ID_W-1:0] r_Q1;
   logic [ROB_ID_W-1:0] r_Q2;
   logic [DATA_W-1:0]   r_pc;
   logic [DATA_W-1:0]   r_imm;
   logic [ROB_ID_W-1:0] r_rob_id;

   logic                w_unit_free;
   logic                w_ready;
   logic                w_fire;
   logic [DATA_W-1:0]   w_V1;
   logic [DATA_W-1:0]   w_V2;
   logic [ROB_ID_W-1:0] w_Q1;
   logic [ROB_ID_W-1:0] w_Q2;
   logic [DATA_W-1:0]   w_snp_V1;
   logic [DATA_W-1:0]   w_snp_V2;
   logic [ROB_ID_W-1:0] w_snp_Q1;
   logic [ROB_ID_W-1:0] w_snp_Q2;

   // The unit full flags do not yet see an insert landing this cycle, so our own strobe blocks reissue.
   assign w_unit_free = bus.inst_is_ls ? (!bus.lsb_full && !r_lsb_en)
                                       : (!bus.rs_full && !r_rs_en);
   assign w_ready     = bus.rdy && !bus.misbranch_flag && !bus.rob_full && w_unit_free;
   assign w_fire      = bus.inst_valid && w_ready;

   assign bus.dispatch_ready   = w_ready;
   assign bus.rf_rs1_idx       = bus.inst_rs1;
   assign bus.rf_rs2_idx       = bus.inst_rs2;
   assign bus.rename_en        = w_fire && (bus.inst_rd != 5'd0);
   assign bus.rename_rd        = bus.inst_rd;
   assign bus.rename_rob_id    = bus.rob_free_id;
   assign bus.rob_alloc_en     = w_fire;
   assign bus.rob_alloc_rd     = bus.inst_rd;
   assign bus.rob_alloc_openum = bus.inst_openum;
   assign bus.rob_alloc_pc     = bus.inst_pc;
   assign bus.rob_q1_query     = bus.rf_Q1;
   assign bus.rob_q2_query     = bus.rf_Q2;

   always_comb begin
      w_V1 = '0;
      w_Q1 = ZERO_ROB;
      if (bus.inst_rs1 != 5'd0) begin
         if (bus.rf_Q1 == ZERO_ROB)
            w_V1 = bus.rf_V1;
         else if (bus.arith_cdb_valid && bus.arith_cdb_rob_id == bus.rf_Q1)
            w_V1 = bus.arith_cdb_result;
         else if (bus.ls_cdb_valid && bus.ls_cdb_rob_id == bus.rf_Q1)
            w_V1 = bus.ls_cdb_result;
         else if (bus.rob_q1_ready)
            w_V1 = bus.rob_q1_value;
         else
            w_Q1 = bus.rf_Q1;
      end
   end

   always_comb begin
      w_V2 = '0;
      w_Q2 = ZERO_ROB;
      if (bus.inst_use_rs2 && bus.inst_rs2 != 5'd0) begin
         if (bus.rf_Q2 == ZERO_ROB)
            w_V2 = bus.rf_V2;
         else if (bus.arith_cdb_valid && bus.arith_cdb_rob_id == bus.rf_Q2)
            w_V2 = bus.arith_cdb_result;
         else if (bus.ls_cdb_valid && bus.ls_cdb_rob_id == bus.rf_Q2)
            w_V2 = bus.ls_cdb_result;
         else if (bus.rob_q2_ready)
            w_V2 = bus.rob_q2_value;
         else
            w_Q2 = bus.rf_Q2;
      end
   end

   // Broadcasts during the landing cycle are folded into the held payload.
   always_comb begin
      w_snp_V1 = r_V1;
      w_snp_Q1 = r_Q1;
      w_snp_V2 = r_V2;
      w_snp_Q2 = r_Q2;
      if (r_Q1 != ZERO_ROB) begin
         if (bus.arith_cdb_valid && bus.arith_cdb_rob_id == r_Q1) begin
            w_snp_V1 = bus.arith_cdb_result;
            w_snp_Q1 = ZERO_ROB;
         end else if (bus.ls_cdb_valid && bus.ls_cdb_rob_id == r_Q1) begin
            w_snp_V1 = bus.ls_cdb_result;
            w_snp_Q1 = ZERO_ROB;
         end
      end
      if (r_Q2 != ZERO_ROB) begin
         if (bus.arith_cdb_valid && bus.arith_cdb_rob_id == r_Q2) begin
            w_snp_V2 = bus.arith_cdb_result;
            w_snp_Q2 = ZERO_ROB;
         end else if (bus.ls_cdb_valid && bus.ls_cdb_rob_id == r_Q2) begin
            w_snp_V2 = bus.ls_cdb_result;
            w_snp_Q2 = ZERO_ROB;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rs_en  <= 1'b0;
         r_lsb_en <= 1'b0;
         r_openum <= NOP;
         r_V1     <= '0;
         r_V2     <= '0;
         r_Q1     <= ZERO_ROB;
         r_Q2     <= ZERO_ROB;
         r_pc     <= '0;
         r_imm    <= '0;
         r_rob_id <= ZERO_ROB;
      end else if (bus.rdy) begin
         if (bus.misbranch_flag) begin
            r_rs_en  <= 1'b0;
            r_lsb_en <= 1'b0;
            r_openum <= NOP;
         end else if (w_fire) begin
            r_rs_en  <= !bus.inst_is_ls;
            r_lsb_en <= bus.inst_is_ls;
            r_openum <= bus.inst_openum;
            r_V1     <= w_V1;
            r_V2     <= w_V2;
            r_Q1     <= w_Q1;
            r_Q2     <= w_Q2;
            r_pc     <= bus.inst_pc;
            r_imm    <= bus.inst_imm;
            r_rob_id <= bus.rob_free_id;
         end else begin
            r_rs_en  <= 1'b0;
            r_lsb_en <= 1'b0;
            if (r_rs_en || r_lsb_en) begin
               r_V1 <= w_snp_V1;
               r_Q1 <= w_snp_Q1;
               r_V2 <= w_snp_V2;
               r_Q2 <= w_snp_Q2;
            end
         end
      end
   end

   assign bus.rs_en      = r_rs_en;
   assign bus.lsb_en     = r_lsb_en;
   assign bus.out_openum = r_openum;
   assign bus.out_V1     = r_V1;
   assign bus.out_V2     = r_V2;
   assign bus.out_Q1     = r_Q1;
   assign bus.out_Q2     = r_Q2;
   assign bus.out_pc     = r_pc;
   assign bus.out_imm    = r_imm;
   assign bus.out_rob_id = r_rob_id;
endmodule

// File: tb/tb_dispatcher.sv
// Directed and randomized bench for the dispatcher, checked against a
// transaction-level model of the issue payload.
module tb_dispatcher;
   localparam int DATA_W   = 32;
   localparam int ROB_ID_W = 5;
   localparam int OPENUM_W = 6;

   typedef struct {
      logic                rs_en;
      logic                lsb_en;
      logic [OPENUM_W-1:0] openum;
      logic [DATA_W-1:0]   V1, V2, pc, imm;
      logic [ROB_ID_W-1:0] Q1, Q2, rob_id;
   } payload_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   payload_t m;

   dispatcher_if #(.DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W), .OPENUM_W(OPENUM_W)) bus ();

   dispatcher #(.DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W), .OPENUM_W(OPENUM_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One source operand: a dependency is satisfied by the first available producer.
   task automatic model_operand(input logic real_src, input logic [ROB_ID_W-1:0] tag,
                                input logic [DATA_W-1:0] rf_val, input logic rob_ready,
                                input logic [DATA_W-1:0] rob_val,
                                output logic [DATA_W-1:0] v, output logic [ROB_ID_W-1:0] q);
      v = 0; q = 0;
      if (!real_src) return;
      if (tag == 0) v = rf_val;
      else if (bus.arith_cdb_valid && bus.arith_cdb_rob_id == tag) v = bus.arith_cdb_result;
      else if (bus.ls_cdb_valid && bus.ls_cdb_rob_id == tag) v = bus.ls_cdb_result;
      else if (rob_ready) v = rob_val;
      else q = tag;
   endtask

   task automatic model_snoop(inout logic [DATA_W-1:0] v, inout logic [ROB_ID_W-1:0] q);
      if (q == 0) return;
      if (bus.arith_cdb_valid && bus.arith_cdb_rob_id == q) begin v = bus.arith_cdb_result; q = 0; end
      else if (bus.ls_cdb_valid && bus.ls_cdb_rob_id == q) begin v = bus.ls_cdb_result; q = 0; end
   endtask

   task automatic model_reset();
      m = '{rs_en: 0, lsb_en: 0, openum: 0, V1: 0, V2: 0, pc: 0, imm: 0, Q1: 0, Q2: 0, rob_id: 0};
   endtask

   task automatic check_regs(input string pfx);
      check({pfx, ".rs_en"},  bus.rs_en,      m.rs_en);
      check({pfx, ".lsb_en"}, bus.lsb_en,     m.lsb_en);
      check({pfx, ".openum"}, bus.out_openum, m.openum);
      check({pfx, ".V1"},     bus.out_V1,     m.V1);
      check({pfx, ".V2"},     bus.out_V2,     m.V2);
      check({pfx, ".Q1"},     bus.out_Q1,     m.Q1);
      check({pfx, ".Q2"},     bus.out_Q2,     m.Q2);
      check({pfx, ".pc"},     bus.out_pc,     m.pc);
      check({pfx, ".imm"},    bus.out_imm,    m.imm);
      check({pfx, ".rob_id"}, bus.out_rob_id, m.rob_id);
   endtask

   // Called just after a negedge with inputs already driven; ends at the following negedge.
   task automatic cycle(input string pfx);
      logic unit_free, ready, fire;
      payload_t nx;
      #1;
      unit_free = bus.inst_is_ls ? (!bus.lsb_full && !m.lsb_en) : (!bus.rs_full && !m.rs_en);
      ready = bus.rdy && !bus.misbranch_flag && !bus.rob_full && unit_free;
      fire  = bus.inst_valid && ready;
      check({pfx, ".ready"},     bus.dispatch_ready, ready);
      check({pfx, ".alloc_en"},  bus.rob_alloc_en,   fire);
      check({pfx, ".rename_en"}, bus.rename_en,      fire && bus.inst_rd != 0);
      check({pfx, ".rename_id"}, bus.rename_rob_id,  bus.rob_free_id);
      check({pfx, ".alloc_pc"},  bus.rob_alloc_pc,   bus.inst_pc);
      check({pfx, ".alloc_op"},  bus.rob_alloc_openum, bus.inst_openum);
      check({pfx, ".alloc_rd"},  bus.rob_alloc_rd,   bus.inst_rd);
      check({pfx, ".rs1_idx"},   bus.rf_rs1_idx,     bus.inst_rs1);
      check({pfx, ".rs2_idx"},   bus.rf_rs2_idx,     bus.inst_rs2);
      check({pfx, ".q1_query"},  bus.rob_q1_query,   bus.rf_Q1);
      check({pfx, ".q2_query"},  bus.rob_q2_query,   bus.rf_Q2);
      nx = m;
      if (bus.rdy) begin
         if (bus.misbranch_flag) begin
            nx.rs_en = 0; nx.lsb_en = 0; nx.openum = 0;
         end else if (fire) begin
            nx.rs_en  = !bus.inst_is_ls;
            nx.lsb_en = bus.inst_is_ls;
            nx.openum = bus.inst_openum;
            nx.pc     = bus.inst_pc;
            nx.imm    = bus.inst_imm;
            nx.rob_id = bus.rob_free_id;
            model_operand(bus.inst_rs1 != 0, bus.rf_Q1, bus.rf_V1, bus.rob_q1_ready,
                          bus.rob_q1_value, nx.V1, nx.Q1);
            model_operand(bus.inst_use_rs2 && bus.inst_rs2 != 0, bus.rf_Q2, bus.rf_V2,
                          bus.rob_q2_ready, bus.rob_q2_value, nx.V2, nx.Q2);
         end else begin
            if (m.rs_en || m.lsb_en) begin
               model_snoop(nx.V1, nx.Q1);
               model_snoop(nx.V2, nx.Q2);
            end
            nx.rs_en = 0; nx.lsb_en = 0;
         end
      end
      @(posedge clk);
      m = nx;
      @(negedge clk);
      check_regs(pfx);
   endtask

   task automatic idle_inputs();
      bus.rdy = 1; bus.misbranch_flag = 0;
      bus.inst_valid = 0; bus.inst_openum = 0; bus.inst_rd = 0; bus.inst_rs1 = 0;
      bus.inst_rs2 = 0; bus.inst_use_rs2 = 0; bus.inst_is_ls = 0;
      bus.inst_pc = 0; bus.inst_imm = 0;
      bus.rf_V1 = 0; bus.rf_V2 = 0; bus.rf_Q1 = 0; bus.rf_Q2 = 0;
      bus.rob_full = 0; bus.rob_free_id = 1;
      bus.rob_q1_ready = 0; bus.rob_q2_ready = 0; bus.rob_q1_value = 0; bus.rob_q2_value = 0;
      bus.arith_cdb_valid = 0; bus.arith_cdb_rob_id = 0; bus.arith_cdb_result = 0;
      bus.ls_cdb_valid = 0; bus.ls_cdb_rob_id = 0; bus.ls_cdb_result = 0;
      bus.rs_full = 0; bus.lsb_full = 0;
   endtask

   task automatic set_inst(input logic is_ls, input logic [4:0] rd, rs1, rs2,
                           input logic [OPENUM_W-1:0] op, input logic [ROB_ID_W-1:0] free_id);
      bus.inst_valid = 1; bus.inst_is_ls = is_ls; bus.inst_rd = rd;
      bus.inst_rs1 = rs1; bus.inst_rs2 = rs2; bus.inst_use_rs2 = 1;
      bus.inst_openum = op; bus.rob_free_id = free_id;
      bus.inst_pc = 32'h1000 + {27'd0, free_id} * 4; bus.inst_imm = {27'd0, rd};
   endtask

   task automatic random_inputs();
      bus.rdy            = ($urandom_range(0, 9) != 0);
      bus.misbranch_flag = ($urandom_range(0, 19) == 0);
      bus.inst_valid     = ($urandom_range(0, 3) != 0);
      bus.inst_openum    = OPENUM_W'($urandom);
      bus.inst_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      bus.inst_rs1       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      bus.inst_rs2       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      bus.inst_use_rs2   = $urandom_range(0, 1);
      bus.inst_is_ls     = $urandom_range(0, 1);
      bus.inst_pc        = $urandom;
      bus.inst_imm       = $urandom;
      bus.rf_V1          = $urandom;
      bus.rf_V2          = $urandom;
      bus.rf_Q1          = ROB_ID_W'($urandom_range(0, 7));
      bus.rf_Q2          = ROB_ID_W'($urandom_range(0, 7));
      bus.rob_full       = ($urandom_range(0, 7) == 0);
      bus.rob_free_id    = ROB_ID_W'($urandom_range(1, 31));
      bus.rob_q1_ready   = $urandom_range(0, 1);
      bus.rob_q2_ready   = $urandom_range(0, 1);
      bus.rob_q1_value   = $urandom;
      bus.rob_q2_value   = $urandom;
      bus.arith_cdb_valid  = $urandom_range(0, 1);
      bus.arith_cdb_rob_id = ROB_ID_W'($urandom_range(1, 7));
      bus.arith_cdb_result = $urandom;
      bus.ls_cdb_valid     = $urandom_range(0, 1);
      bus.ls_cdb_rob_id    = ROB_ID_W'($urandom_range(1, 7));
      bus.ls_cdb_result    = $urandom;
      bus.rs_full        = ($urandom_range(0, 4) == 0);
      bus.lsb_full       = ($urandom_range(0, 4) == 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle_inputs();
      model_reset();
      rst = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      check_regs("reset");

      // ADD x3,x1,x2 with ready operands
      set_inst(0, 5'd3, 5'd1, 5'd2, 6'd1, 5'd4);
      bus.rf_V1 = 5; bus.rf_V2 = 7;
      #1;
      check("add.rename_en", bus.rename_en, 1);
      check("add.rename_rd", bus.rename_rd, 3);
      cycle("add");
      check("add.rs_en_c", bus.rs_en, 1);
      check("add.V1_c", bus.out_V1, 5);
      check("add.V2_c", bus.out_V2, 7);
      check("add.rob_id_c", bus.out_rob_id, 4);

      // Second RS instruction is held back by the landing strobe, then issues with an arith forward
      set_inst(0, 5'd5, 5'd6, 5'd0, 6'd2, 5'd5);
      bus.rf_Q1 = 6; bus.arith_cdb_valid = 1; bus.arith_cdb_rob_id = 6; bus.arith_cdb_result = 32'h11;
      #1;
      check("rsrs.blocked", bus.dispatch_ready, 0);
      cycle("rsrs_wait");
      cycle("rsrs_fire");
      check("fwd.Q1_c", bus.out_Q1, 0);
      check("fwd.V1_c", bus.out_V1, 32'h11);

      // LSB right after RS, unresolved rs2, then LS CDB during landing
      idle_inputs();
      set_inst(1, 5'd7, 5'd0, 5'd4, 6'd3, 5'd6);
      bus.rf_Q2 = 9;
      #1;
      check("rslsb.ready", bus.dispatch_ready, 1);
      cycle("lsb_fire");
      check("lsb.Q2_c", bus.out_Q2, 9);
      check("lsb.en_c", bus.lsb_en, 1);
      idle_inputs();
      bus.ls_cdb_valid = 1; bus.ls_cdb_rob_id = 9; bus.ls_cdb_result = 32'hAB;
      cycle("lsb_snoop");
      check("snoop.Q2_c", bus.out_Q2, 0);
      check("snoop.V2_c", bus.out_V2, 32'hAB);

      // Flush while an RS insert is landing and another instruction is offered
      idle_inputs();
      set_inst(0, 5'd8, 5'd1, 5'd2, 6'd4, 5'd7);
      cycle("pre_flush");
      set_inst(1, 5'd9, 5'd1, 5'd2, 6'd5, 5'd8);
      bus.misbranch_flag = 1;
      #1;
      check("flush.alloc", bus.rob_alloc_en, 0);
      check("flush.rename", bus.rename_en, 0);
      cycle("flush");
      check("flush.rs_en_c", bus.rs_en, 0);
      check("flush.lsb_en_c", bus.lsb_en, 0);
      check("flush.op_c", bus.out_openum, 0);

      // Asynchronous reset mid-issue
      idle_inputs();
      set_inst(0, 5'd10, 5'd1, 5'd2, 6'd6, 5'd9);
      cycle("pre_reset");
      #2 rst = 0;
      #1;
      check("areset.rs_en", bus.rs_en, 0);
      check("areset.op", bus.out_openum, 0);
      model_reset();
      @(negedge clk);
      rst = 1;
      idle_inputs();
      check_regs("after_reset");

      for (int i = 0; i < 2000; i++) begin
         random_inputs();
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dispatcher.md
Name: dispatcher

Overview:
- Issue stage directly upstream of the arithmetic reservation station and the load/store buffer.
- Takes one decoded instruction per handshake from the instruction queue and allocates its ROB entry and destination rename at the handshake edge.
- Resolves source operands (V/Q) from the register file, ROB and both CDBs, then delivers a registered, CDB-clean payload to the RS or the LSB one cycle later.

Parameters:
- DATA_W, 32, operand/pc/imm width.
- ROB_ID_W, 5, ROB tag width; tag 0 = "no dependency" (ZERO_ROB).
- OPENUM_W, 6, opcode enum width; 0 = NOP.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low = freeze
inst_valid  in  1  IQ has an instruction
inst_openum  in  OPENUM_W  decoded op
inst_rd / inst_rs1 / inst_rs2  in  5 each  register indices
inst_use_rs2  in  1  rs2 is a real source
inst_is_ls  in  1  route to LSB (else RS)
inst_pc / inst_imm  in  DATA_W each  pc, immediate
dispatch_ready  out  1  IQ handshake; fire = inst_valid & dispatch_ready
rf_rs1_idx / rf_rs2_idx  out  5 each  combinational = inst_rs1/inst_rs2
rf_V1 / rf_V2  in  DATA_W each  register values
rf_Q1 / rf_Q2  in  ROB_ID_W each  register tags
rename_en  out  1  = fire & (inst_rd != 0)
rename_rd  out  5  = inst_rd
rename_rob_id  out  ROB_ID_W  = rob_free_id
rob_full  in  1  ROB cannot allocate
rob_free_id  in  ROB_ID_W  tag allocated on next alloc
rob_alloc_en  out  1  = fire
rob_alloc_rd / rob_alloc_openum / rob_alloc_pc  out  5 / OPENUM_W / DATA_W  ROB entry fields
rob_q1_query / rob_q2_query  out  ROB_ID_W each  = rf_Q1/rf_Q2
rob_q1_ready / rob_q2_ready  in  1 each  queried entry finished
rob_q1_value / rob_q2_value  in  DATA_W each  its result
arith_cdb_valid, arith_cdb_rob_id, arith_cdb_result  in  1/ROB_ID_W/DATA_W  Arith CDB
ls_cdb_valid, ls_cdb_rob_id, ls_cdb_result  in  1/ROB_ID_W/DATA_W  LS CDB
rs_full / lsb_full  in  1 each  unit full
rs_en / lsb_en  out  1 each  registered insert strobe
out_openum, out_V1, out_V2, out_Q1, out_Q2, out_pc, out_imm, out_rob_id  out  registered payload shared by RS and LSB
misbranch_flag  in  1  flush

Behaviour:
- Reset (rst=0, async): rs_en = lsb_en = 0; all registered payload = 0 (openum NOP, Q = ZERO_ROB).
- dispatch_ready = rdy & !misbranch_flag & !rob_full & (inst_is_ls ? (!lsb_full & !lsb_en) : (!rs_full & !rs_en)).
- The !rs_en / !lsb_en term is the in-flight guard: the unit's full flag does not yet count an insert landing this cycle, so back-to-back issue to the same unit is blocked. Alternating RS/LSB issue runs at full rate.
- Combinational outputs rob_alloc_en, rename_en, rob_alloc_*, rename_* act in the fire cycle; ROB tail and RF tag update on that edge.
- Operand resolution, per source, first match wins:
  1. Index 0, or rs2 with !inst_use_rs2 → V=0, Q=0.
  2. rf_Q==0 → V=rf_V, Q=0.
  3. arith_cdb_valid & tag match → arith result, Q=0.
  4. ls_cdb_valid & tag match → LS result, Q=0.
  5. rob_q_ready → rob value, Q=0.
  6. Otherwise V=0, Q=rf_Q.
- Lookup uses pre-rename RF state, so rd==rs1 in the same instruction reads the old tag.
- Registered stage, on edge with rdy=1 and no flush:
  - If fire: latch resolved payload, out_rob_id=rob_free_id; assert rs_en or lsb_en per inst_is_ls.
  - Otherwise drop both enables, hold payload.
- Latency: fire at edge t → insert strobe high during cycle t+1, exactly one cycle.
- While an enable is high, registered Q fields are also updated from CDB broadcasts in that cycle (tag match → Q=0, V=result). This covers CDB events between lookup and landing; the consumer also snoops its own landing cycle, so no broadcast is missed.
- misbranch_flag=1 (synchronous, priority over fire): dispatch_ready=0, rob_alloc_en=0, rename_en=0; next edge clears rs_en/lsb_en and sets out_openum=NOP.
- rdy=0: no fire; all registers hold (enables hold too; consumers also gate on rdy).
- Simultaneous arith and LS CDB match on the same tag cannot occur; arith is given priority anyway.

Test Plan:
- Reset mid-issue: rs_en=1, drive rst=0 asynchronously → rs_en=0 and out_openum=0 before the next clk edge.
- ADD x3,x1,x2 with rf_Q1=rf_Q2=0, V=5/7, rob_free_id=4 → fire; next cycle rs_en=1, V1=5, V2=7, Q1=Q2=0, out_rob_id=4; rename_en=1 (rd=3, id 4) in the fire cycle.
- rf_Q1=6 with arith_cdb_valid, id 6, result 0x11 in the same cycle → out_Q1=0, out_V1=0x11.
- rf_Q2=9 with nothing matching → out_Q2=9; then LS CDB id 9 with 0xAB during the landing cycle → payload shows Q2=0, V2=0xAB.
- Two consecutive RS instructions with rs_full=0 → issued on alternate cycles (second waits one cycle); an RS then LSB pair issues back-to-back.
- misbranch_flag pulse while inst_valid=1 and rs_en=1 → no ROB alloc or rename that cycle; next cycle rs_en=0, lsb_en=0.
